// File: rtl/axi_lite_mem_checker_if.sv
// AXI4-Lite bus bundle between the memory checker (master) and the memory under test (slave).
// Latency: none, wires only.
// Backpressure: standard AXI valid/ready on all five channels.
// Ports: aw (addr/valid/ready), w (data/strb/valid/ready), b (resp/valid/ready),
//        ar (addr/valid/ready), r (data/resp/valid/ready).
interface axi_lite_mem_checker_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_mem_checker.sv
// AXI4-Lite test master: writes count items of a seeded pattern over a window, reads each back and checks it.
// Latency: one item per WR/WB/RA/RD/NEXT pass, 5 cycles plus slave wait states; done_o pulses after the last item.
// Backpressure: each channel holds valid with stable payload until its ready; the FSM waits indefinitely unless
//   MEMCHK_TIMEOUT_EN is defined, in which case a handshake stalled for TIMEOUT_CYCLES aborts the run.
// Ports: clk_i/rst_i (sync active-high); start_i, size_i, base_addr_i, count_i, pattern_i run setup;
//   busy_o, done_o, pass_o, err_count_o, first_err_addr_o, timeout_o status; axi = AXI4-Lite master port.
module axi_lite_mem_checker #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            size_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  count_i,
  input  logic [DATA_WIDTH-1:0] pattern_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [CNT_WIDTH-1:0]  err_count_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic                  timeout_o,
  axi_lite_mem_checker_if.master axi
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RA, S_RD, S_NEXT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  idx_q, idx_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  item_err_q, item_err_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;
  logic                  tmo_hit;

  // A 32-bit bus has no dword lanes; treat size 3 as word there.
  logic [1:0]            size_in;
  logic [3:0]            nbytes_in;
  logic [ADDR_WIDTH-1:0] base_aligned;
  assign size_in      = (LSB == 2 && size_i == 2'd3) ? 2'd2 : size_i;
  assign nbytes_in    = 4'd1 << size_in;
  assign base_aligned = base_addr_i & ~(ADDR_WIDTH'(nbytes_in) - ADDR_WIDTH'(1));

  // Lane placement of the current item. lane_mask keeps the lane bits that select which
  // (1<<size)-byte slot of the bus word is addressed; the remaining bits index into d_k.
  logic [3:0]            nbytes;
  logic [LSB-1:0]        lane_mask;
  logic [DATA_WIDTH-1:0] item_data;
  logic [DATA_WIDTH-1:0] wdata;
  logic [NB-1:0]         wstrb;
  logic [DATA_WIDTH-1:0] byte_en;
  logic                  rd_mismatch;

  always_comb begin
    nbytes    = 4'd1 << size_q;
    lane_mask = ~LSB'(nbytes - 4'd1);
    item_data = pattern_q + DATA_WIDTH'(idx_q);
    wdata     = '0;
    wstrb     = '0;
    byte_en   = '0;
    for (int i = 0; i < NB; i++) begin
      logic [LSB-1:0] j;
      j = LSB'(i) & ~lane_mask;
      wdata[8*i +: 8]   = item_data[{j, 3'b000} +: 8];
      wstrb[i]          = ((LSB'(i) & lane_mask) == (addr_q[LSB-1:0] & lane_mask));
      byte_en[8*i +: 8] = {8{wstrb[i]}};
    end
    rd_mismatch = |((axi.rdata ^ wdata) & byte_en);
  end

  assign axi.awaddr = addr_q;
  assign axi.araddr = addr_q;
  assign axi.wdata  = wdata;
  assign axi.wstrb  = wstrb;

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    addr_d      = addr_q;
    pattern_d   = pattern_q;
    count_d     = count_q;
    idx_d       = idx_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    item_err_d  = item_err_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          size_d      = size_in;
          addr_d      = base_aligned;
          pattern_d   = pattern_i;
          count_d     = count_i;
          idx_d       = '0;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          item_err_d  = 1'b0;
          err_cnt_d   = '0;
          first_err_d = '0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          state_d     = (count_i == '0) ? S_DONE : S_WR;
        end
      end
      S_WR: begin
        // AW and W are independent; each valid drops on its own handshake.
        axi.awvalid = !aw_done_q;
        axi.wvalid  = !w_done_q;
        aw_done_d   = aw_done_q | axi.awready;
        w_done_d    = w_done_q | axi.wready;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WB;
        end
      end
      S_WB: begin
        axi.bready = 1'b1;
        if (axi.bvalid) begin
          item_err_d = (axi.bresp != 2'b00);
          state_d    = S_RA;
        end
      end
      S_RA: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_d = S_RD;
      end
      S_RD: begin
        axi.rready = 1'b1;
        if (axi.rvalid) begin
          // Write and read failures of one item count once.
          if (item_err_q || axi.rresp != 2'b00 || rd_mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            if (err_cnt_q == '0) first_err_d = addr_q;
          end
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        idx_d      = idx_q + CNT_WIDTH'(1);
        addr_d     = addr_q + ADDR_WIDTH'(nbytes);
        item_err_d = 1'b0;
        state_d    = (idx_d == count_q) ? S_DONE : S_WR;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (tmo_hit) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      timeout_d = 1'b1;
      state_d   = S_DONE;
    end

    // The verdict is registered on DONE entry so it is valid alongside the done pulse.
    if (state_d == S_DONE && state_q != S_DONE) begin
      pass_d = (err_cnt_d == '0) && !timeout_d;
    end
  end

`ifdef MEMCHK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q inside {S_WR, S_WB, S_RA, S_RD}) &&
                   (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Restart on every state change so the limit applies per handshake.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d != state_q)     tmo_cnt_d = '0;
    else if (tmo_cnt_q != '1)   tmo_cnt_d = tmo_cnt_q + TW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      size_q      <= '0;
      addr_q      <= '0;
      pattern_q   <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      item_err_q  <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      pattern_q   <= pattern_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      item_err_q  <= item_err_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy_o           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o           = (state_q == S_DONE);
  assign pass_o           = pass_q;
  assign err_count_o      = err_cnt_q;
  assign first_err_addr_o = first_err_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_axi_lite_mem_checker.sv
// Bench for axi_lite_mem_checker: byte-addressed slave memory with optional ready stalls,
// read corruption and error responses; per-item write/read expectations in scoreboard queues.
module tb_axi_lite_mem_checker;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [1:0]    size_i;
  logic [AW-1:0] base_addr_i;
  logic [CW-1:0] count_i;
  logic [DW-1:0] pattern_i;
  logic          busy_o, done_o, pass_o, timeout_o;
  logic [CW-1:0] err_count_o;
  logic [AW-1:0] first_err_addr_o;

  axi_lite_mem_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_mem_checker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(256)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .size_i(size_i),
    .base_addr_i(base_addr_i), .count_i(count_i), .pattern_i(pattern_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_count_o(err_count_o),
    .first_err_addr_o(first_err_addr_o), .timeout_o(timeout_o), .axi(bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    strb;
    logic [DW-1:0] data;
  } wexp_t;

  wexp_t         wq[$];
  logic [AW-1:0] arq[$];

  // Slave controls.
  bit            stall    = 0;
  bit            aw_stuck = 0;
  bit            rresp_err = 0;
  bit            corrupt_en = 0;
  logic [AW-1:0] corrupt_addr = '0;
  int            stab_viol = 0;

  logic [7:0]    mem [logic [AW-1:0]];
  logic          aw_have, w_have;
  logic [AW-1:0] aw_a;
  logic [DW-1:0] w_d;
  logic [7:0]    w_s;
  logic          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [AW-1:0] p_awa, p_ara;
  logic [DW-1:0] p_wd;
  logic [7:0]    p_ws;

  always @(posedge clk_i) begin
    if (rst_i) begin
      bus.awready <= 1'b1; bus.wready <= 1'b1; bus.arready <= 1'b1;
      bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
      bus.rvalid <= 1'b0; bus.rresp <= 2'b00; bus.rdata <= '0;
      aw_have <= 1'b0; w_have <= 1'b0; aw_a <= '0; w_d <= '0; w_s <= '0;
      p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0;
      p_awr <= 1'b0; p_wr <= 1'b0; p_arr <= 1'b0;
      p_awa <= '0; p_ara <= '0; p_wd <= '0; p_ws <= '0;
    end else begin
      logic          a_ok, d_ok;
      logic [AW-1:0] a, wa;
      logic [DW-1:0] d, rd;
      logic [7:0]    s;
      // A valid that was stalled last cycle must still be up with the same payload.
      if (p_awv && !p_awr && !(bus.awvalid && bus.awaddr == p_awa)) stab_viol++;
      if (p_wv && !p_wr && !(bus.wvalid && bus.wdata == p_wd && bus.wstrb == p_ws)) stab_viol++;
      if (p_arv && !p_arr && !(bus.arvalid && bus.araddr == p_ara)) stab_viol++;
      p_awv <= bus.awvalid; p_awr <= bus.awready; p_awa <= bus.awaddr;
      p_wv  <= bus.wvalid;  p_wr  <= bus.wready;  p_wd <= bus.wdata; p_ws <= bus.wstrb;
      p_arv <= bus.arvalid; p_arr <= bus.arready; p_ara <= bus.araddr;

      a_ok = aw_have || (bus.awvalid && bus.awready);
      d_ok = w_have  || (bus.wvalid && bus.wready);
      a = aw_have ? aw_a : bus.awaddr;
      d = w_have ? w_d : bus.wdata;
      s = w_have ? w_s : bus.wstrb;
      if (a_ok && d_ok && !bus.bvalid) begin
        wa = a & ~AW'(7);
        for (int i = 0; i < 8; i++) if (s[i]) mem[wa + AW'(i)] = d[8*i +: 8];
        if (wq.size() == 0) chk("wr.unexpected", 1, 0);
        else begin
          wexp_t e;
          e = wq.pop_front();
          chk("wr.addr", 64'(a), 64'(e.addr));
          chk("wr.strb", 64'(s), 64'(e.strb));
          chk("wr.data", d, e.data);
        end
        bus.bvalid <= 1'b1; bus.bresp <= 2'b00;
        aw_have <= 1'b0; w_have <= 1'b0;
      end else begin
        if (bus.awvalid && bus.awready) begin aw_have <= 1'b1; aw_a <= bus.awaddr; end
        if (bus.wvalid && bus.wready) begin w_have <= 1'b1; w_d <= bus.wdata; w_s <= bus.wstrb; end
      end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;

      if (bus.arvalid && bus.arready) begin
        wa = bus.araddr & ~AW'(7);
        for (int i = 0; i < 8; i++) rd[8*i +: 8] = mem.exists(wa + AW'(i)) ? mem[wa + AW'(i)] : 8'h00;
        if (corrupt_en && bus.araddr == corrupt_addr) rd = ~rd;
        if (arq.size() == 0) chk("rd.unexpected", 1, 0);
        else chk("rd.addr", 64'(bus.araddr), 64'(arq.pop_front()));
        bus.rdata  <= rd;
        bus.rresp  <= rresp_err ? 2'b10 : 2'b00;
        bus.rvalid <= 1'b1;
      end else if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0;
      end

      bus.awready <= aw_stuck ? 1'b0 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);
      bus.wready  <= stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.arready <= stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Expected items: aligned base, step 1<<size, data truncated then replicated by multiplication.
  task automatic push_items(input logic [1:0] sz, input logic [AW-1:0] base,
                            input logic [CW-1:0] cnt, input logic [DW-1:0] pat);
    int            nb;
    logic [AW-1:0] a;
    logic [DW-1:0] m, rep, dk;
    nb = 1 << sz;
    a  = base & ~AW'(nb - 1);
    case (sz)
      2'd0: begin m = 64'hFF;       rep = 64'h0101010101010101; end
      2'd1: begin m = 64'hFFFF;     rep = 64'h0001000100010001; end
      2'd2: begin m = 64'hFFFFFFFF; rep = 64'h0000000100000001; end
      default: begin m = '1;        rep = 64'h1; end
    endcase
    for (int k = 0; k < int'(cnt); k++) begin
      wexp_t e;
      dk = (pat + 64'(k)) & m;
      e.addr = a;
      e.data = dk * rep;
      e.strb = 8'(((1 << nb) - 1) << a[2:0]);
      wq.push_back(e);
      arq.push_back(a);
      a = a + AW'(nb);
    end
  endtask

  task automatic run(input string name, input logic [1:0] sz, input logic [AW-1:0] base,
                     input logic [CW-1:0] cnt, input logic [DW-1:0] pat,
                     input int exp_err, input logic [AW-1:0] exp_first, input bit exp_pass,
                     input bit chk_lat, input bit poke);
    int cyc;
    push_items(sz, base, cnt, pat);
    @(negedge clk_i);
    start_i = 1'b1; size_i = sz; base_addr_i = base; count_i = cnt; pattern_i = pat;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 1;
    while (!done_o && cyc < 2000) begin
      if (poke && cyc == 3) begin
        start_i = 1'b1; count_i = 16'd9; base_addr_i = 32'h7777_0000; size_i = 2'd3;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
      cyc++;
    end
    start_i = 1'b0;
    chk({name, ".done"}, 64'(done_o), 1);
    if (chk_lat) chk({name, ".latency"}, 64'(cyc), 6);
    chk({name, ".busy_at_done"}, 64'(busy_o), 0);
    chk({name, ".err_count"}, 64'(err_count_o), 64'(exp_err));
    chk({name, ".pass"}, 64'(pass_o), 64'(exp_pass));
    if (exp_err != 0) chk({name, ".first_err"}, 64'(first_err_addr_o), 64'(exp_first));
    chk({name, ".wq_left"}, 64'(wq.size()), 0);
    chk({name, ".arq_left"}, 64'(arq.size()), 0);
    @(negedge clk_i);
    chk({name, ".done_pulse"}, 64'(done_o), 0);
    chk({name, ".pass_held"}, 64'(pass_o), 64'(exp_pass));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_i = 1'b1; start_i = 1'b0; size_i = '0; base_addr_i = '0; count_i = '0; pattern_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst.valids", 64'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}), 0);
    chk("rst.busy", 64'(busy_o), 0);
    chk("rst.done", 64'(done_o), 0);
    chk("rst.pass", 64'(pass_o), 0);
    chk("rst.timeout", 64'(timeout_o), 0);
    chk("rst.err_count", 64'(err_count_o), 0);
    chk("rst.first_err", 64'(first_err_addr_o), 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    run("word1",   2'd2, 32'h0000_1018, 16'd1, 64'h100, 0, '0, 1'b1, 1'b1, 1'b0);
    run("dword4",  2'd3, 32'h0000_10C0, 16'd4, 64'h200, 0, '0, 1'b1, 1'b0, 1'b0);
    run("byte8",   2'd0, 32'h0000_1003, 16'd8, 64'h5A,  0, '0, 1'b1, 1'b0, 1'b0);
    corrupt_en = 1; corrupt_addr = 32'h0000_1008;
    run("corrupt", 2'd2, 32'h0000_1000, 16'd4, 64'h300, 1, 32'h0000_1008, 1'b0, 1'b0, 1'b0);
    corrupt_en = 0;
    rresp_err = 1;
    run("rresp",   2'd2, 32'h0000_1100, 16'd3, 64'h7,   3, 32'h0000_1100, 1'b0, 1'b0, 1'b0);
    rresp_err = 0;
    stall = 1;
    run("stall",   2'd1, 32'h0000_2003, 16'd6, 64'hFFFE, 0, '0, 1'b1, 1'b0, 1'b1);
    run("wrap",    2'd2, 32'hFFFF_FFF8, 16'd4, 64'hDEAD_BEEF_0000_0001, 0, '0, 1'b1, 1'b0, 1'b0);
    stall = 0;
    run("count0",  2'd2, 32'h0000_4000, 16'd0, 64'h1,   0, '0, 1'b1, 1'b0, 1'b0);
    chk("stability", 64'(stab_viol), 0);

    // Reset while the read data phase is pending.
    push_items(2'd2, 32'h0000_3000, 16'd2, 64'h55);
    @(negedge clk_i);
    start_i = 1'b1; size_i = 2'd2; base_addr_i = 32'h0000_3000; count_i = 16'd2; pattern_i = 64'h55;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 0;
    while (!bus.rready && cyc < 50) begin @(negedge clk_i); cyc++; end
    chk("rstmid.reached_rd", 64'(bus.rready), 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rstmid.valids", 64'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}), 0);
    chk("rstmid.busy", 64'(busy_o), 0);
    chk("rstmid.err_count", 64'(err_count_o), 0);
    rst_i = 1'b0;
    wq.delete();
    arq.delete();
    @(negedge clk_i);

`ifdef MEMCHK_TIMEOUT_EN
    aw_stuck = 1;
    @(negedge clk_i);
    start_i = 1'b1; size_i = 2'd2; base_addr_i = 32'h0000_5000; count_i = 16'd1; pattern_i = 64'h9;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 1;
    while (!done_o && cyc < 600) begin @(negedge clk_i); cyc++; end
    chk("tmo.done", 64'(done_o), 1);
    chk("tmo.window", 64'(cyc >= 256 && cyc <= 258), 1);
    chk("tmo.flag", 64'(timeout_o), 1);
    chk("tmo.pass", 64'(pass_o), 0);
    @(negedge clk_i);
    chk("tmo.valids", 64'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}), 0);
    aw_stuck = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
